id_ex_stage: RTL

//  ID/EX pipeline register for the 5-stage MIPS core. Sits between decode (main_control, register

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode control/data, inserts load-use and flush bubbles,
// honours a downstream hold and counts inserted bubbles (saturating).
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  id_stall,
  output logic [CNT_W-1:0]      bubble_count
);

  logic loadUse;
  logic rtHit;
  logic takeBubble;
  logic capture;
  logic ctlKeep;
  logic cntSat;

  // $0 is hardwired zero, so a load into it never creates a dependency
  assign rtHit = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign loadUse = id_valid & ex_valid & ex_mem_read
                 & (ex_rt != '0) & rtHit;

  assign id_stall = loadUse | ex_hold;

  // flush outranks hold; a load-use bubble only lands when not held
  assign takeBubble = flush | (~ex_hold & loadUse);
  assign capture    = ~flush & ~ex_hold & ~loadUse;
  assign ctlKeep    = capture & id_valid;
  assign cntSat     = (bubble_count == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_jump       <= 1'b0;
    end else if (takeBubble | capture) begin
      ex_valid      <= capture & id_valid;
      ex_reg_dst    <= ctlKeep & id_reg_dst;
      ex_branch     <= ctlKeep & id_branch;
      ex_mem_read   <= ctlKeep & id_mem_read;
      ex_mem_to_reg <= ctlKeep & id_mem_to_reg;
      ex_alu_op     <= ctlKeep ? id_alu_op : 2'b00;
      ex_mem_write  <= ctlKeep & id_mem_write;
      ex_alu_src    <= ctlKeep & id_alu_src;
      ex_reg_write  <= ctlKeep & id_reg_write;
      ex_jump       <= ctlKeep & id_jump;
    end
  end

  // operands and fields still flow when id_valid=0; only a bubble clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm_ext  <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else if (takeBubble) begin
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm_ext  <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else if (capture) begin
      ex_pc_plus4 <= id_pc_plus4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm_ext  <= id_imm_ext;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (takeBubble & id_valid & ~cntSat) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
